fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC and the F/D pipeline register,
// applies delayed-slot redirects from D and halts on an illegal fetch address.
module fetch_unit #(
  parameter logic [31:0] PC_INIT  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  output logic [31:0] imaddr,
  input  logic [31:0] instr,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        addr_err
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'b00,
    SEL_BRANCH = 2'b01,
    SEL_JUMP   = 2'b10,
    SEL_JREG   = 2'b11
  } npc_sel_t;

  // Upper bound is computed in 33 bits so a memory ending at 4 GiB cannot wrap.
  localparam logic [32:0] PC_LO = {1'b0, PC_INIT};
  localparam logic [32:0] PC_HI = {1'b0, PC_INIT} + (33'(IM_WORDS) << 2);

  state_t      r_state;
  logic [31:0] r_pc_f;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic        r_valid_d;
  logic        r_addr_err;

  logic [31:0] w_pc_f_plus4;
  logic [31:0] w_br_off;
  logic [31:0] w_npc;
  logic        w_npc_legal;
  npc_sel_t    w_sel;

  assign w_sel        = npc_sel_t'(npc_sel);
  assign w_pc_f_plus4 = r_pc_f + 32'd4;
  assign w_br_off     = {{14{imm16[15]}}, imm16, 2'b00};

  // A bubble in D carries no redirect, so its select field is not trusted.
  always_comb begin
    w_npc = w_pc_f_plus4;
    if (r_valid_d) begin
      unique case (w_sel)
        SEL_SEQ:    w_npc = w_pc_f_plus4;
        SEL_BRANCH: w_npc = r_pc_d + 32'd4 + w_br_off;
        SEL_JUMP:   w_npc = {r_pc_d[31:28], instr_index, 2'b00};
        SEL_JREG:   w_npc = rs_val;
        default:    w_npc = w_pc_f_plus4;
      endcase
    end
  end

  always_comb begin
    w_npc_legal = 1'b0;
    if ((w_npc[1:0] == 2'b00) &&
        ({1'b0, w_npc} >= PC_LO) &&
        ({1'b0, w_npc} <  PC_HI)) begin
      w_npc_legal = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_pc_f     <= PC_INIT;
      r_instr_d  <= '0;
      r_pc_d     <= '0;
      r_valid_d  <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (!stall) begin
            r_instr_d <= instr;
            r_pc_d    <= r_pc_f;
            r_valid_d <= 1'b1;
            if (w_npc_legal) begin
              r_pc_f <= w_npc;
            end else begin
              r_addr_err <= 1'b1;
              r_state    <= ST_HALT;
            end
          end
        end
        ST_HALT: begin
          r_valid_d  <= 1'b0;
          r_addr_err <= 1'b1;
        end
        default: begin
          r_state <= ST_HALT;
        end
      endcase
    end
  end

  assign imaddr   = r_pc_f;
  assign instr_d  = r_instr_d;
  assign pc_d     = r_pc_d;
  assign pc8_d    = r_pc_d + 32'd8;
  assign valid_d  = r_valid_d;
  assign addr_err = r_addr_err;

endmodule
